seg7_serial_drv: RTL



---
 rtl/seg7_serial_drv.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_serial_drv.sv
// ---------------------------------------------------------------------------
// seg7_serial_drv
//
// Serial seven-segment driver. Takes the 32-bit display value (8 hex digits),
// 8 decimal-point bits and 8 blink-enable bits. It decodes every digit to
// active-low segments and applies blink blanking. The resulting 64-bit frame
// is shifted MSB first into an external shift-register display chain. It
// generates its own shift clock and a latch strobe, and it refreshes
// continuously while en is high.
//
// Frame layout: byte i = frame[8i+7:8i] = {dp,g,f,e,d,c,b,a}, active low.
//
// Parameters:
//   CLK_DIV  system-clock cycles per seg_clk half-period (>= 1)
//   BLINK_W  width of the free-running blink counter (phase = MSB)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          refresh enable, sampled only while idle
//   disp_num    display value, digit i = disp_num[4i+3:4i]
//   point_in    point_in[i]=1 lights the decimal point of digit i
//   le_in       le_in[i]=1 makes digit i blink
//   seg_clk     shift clock to the display chain
//   seg_sout    serial data, MSB first
//   seg_latch   parallel-load strobe, active high
//   seg_clrn    display chain clear, active low
//   busy        high while a frame is loaded, shifted or latched
//   frame_done  one-cycle pulse on the last latch cycle
//
// Optional feature (macro SEG7_RAW_EN):
//   raw_mode    when 1 at LOAD, the frame is taken verbatim from raw_seg
//   raw_seg     64-bit raw segment frame (blink blanking still applies)
// ---------------------------------------------------------------------------
module seg7_serial_drv #(
  parameter int CLK_DIV = 4,
  parameter int BLINK_W = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] disp_num,
  input  logic [7:0]  point_in,
  input  logic [7:0]  le_in,
`ifdef SEG7_RAW_EN
  input  logic        raw_mode,
  input  logic [63:0] raw_seg,
`endif
  output logic        seg_clk,
  output logic        seg_sout,
  output logic        seg_latch,
  output logic        seg_clrn,
  output logic        busy,
  output logic        frame_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  // Count value one before DIV_LAST. It is only used when CLK_DIV >= 2.
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [5:0]         bit_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [63:0]        frame;
  logic [63:0]        frame_next;

  // Hex digit to {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A blanked digit is fully dark, including its decimal point.
  function automatic logic [7:0] blank_byte(input logic [7:0] b, input logic blank);
    return blank ? 8'hFF : b;
  endfunction

  assign blink_phase = blink_cnt[BLINK_W-1];

  // Frame assembled from the live inputs. It is captured only during LOAD.
  always_comb begin
    frame_next = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef SEG7_RAW_EN
      frame_next[8*i +: 8] = blank_byte(
        raw_mode ? raw_seg[8*i +: 8]
                 : {~point_in[i], hex_to_seg(disp_num[4*i +: 4])},
        le_in[i] & blink_phase);
`else
      frame_next[8*i +: 8] = blank_byte(
        {~point_in[i], hex_to_seg(disp_num[4*i +: 4])},
        le_in[i] & blink_phase);
`endif
    end
  end

  // Free-running blink counter. It wraps naturally at 2^BLINK_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // The chain clear is held low only while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_clrn <= 1'b0;
    end else begin
      seg_clrn <= 1'b1;
    end
  end

  // Frame snapshot. This is data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      frame <= frame_next;
    end
  end

  // Control FSM with registered outputs. Each output is updated on the edge
  // that enters the state in which it must hold, so it lines up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      seg_clk    <= 1'b0;
      seg_sout   <= 1'b1;
      seg_latch  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end

        LOAD: begin
          // The frame register is written on this same edge. The first bit
          // therefore comes straight from the assembled frame.
          state    <= SHIFT;
          bit_cnt  <= 6'd63;
          div_cnt  <= '0;
          seg_clk  <= 1'b0;
          seg_sout <= frame_next[63];
        end

        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!seg_clk) begin
              // Rising edge lands mid-bit while the data is stable.
              seg_clk <= 1'b1;
            end else if (bit_cnt == 6'd0) begin
              state      <= LATCH;
              seg_clk    <= 1'b0;
              seg_sout   <= 1'b1;
              seg_latch  <= 1'b1;
              frame_done <= (CLK_DIV == 1);
            end else begin
              // The next bit is presented as seg_clk falls.
              bit_cnt  <= bit_cnt - 6'd1;
              seg_clk  <= 1'b0;
              seg_sout <= frame[bit_cnt - 6'd1];
            end
          end
        end

        LATCH: begin
          if (div_cnt == DIV_LAST) begin
            state     <= IDLE;
            div_cnt   <= '0;
            seg_latch <= 1'b0;
            busy      <= 1'b0;
          end else begin
            div_cnt    <= div_cnt + 1'b1;
            frame_done <= (div_cnt == DIV_PRE);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
